// File: rtl/tmds_gearbox_pkg.sv
// Shared constants and helpers for the TMDS gearbox.
// The PRBS7 constants are used only when TMDS_GEARBOX_PRBS_EN is defined.
package tmds_gearbox_pkg;

  localparam int TMDS_SYM_W = 10;

  // x^7 + x^6 + 1: feedback is bit 6 xor bit 5 of the state.
  localparam logic [6:0] PRBS7_TAPS = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // The clock lane is high for the first half of every symbol period.
  function automatic logic clk_bits(input int unsigned pos, input int unsigned k,
                                    input int unsigned sym_w);
    return ((pos + k) % sym_w) < (sym_w / 2);
  endfunction

endpackage

// File: rtl/tmds_gearbox_if.sv
// Symbol input handshake plus serial-side outputs of the TMDS gearbox.
interface tmds_gearbox_if
  import tmds_gearbox_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int SYM_W    = TMDS_SYM_W,
  parameter int OUT_W    = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*SYM_W-1:0] in_data;
  logic [CHANNELS*OUT_W-1:0] out_data;
  logic [OUT_W-1:0]          out_clk;
  logic                      underflow;

  modport master (output in_valid, in_data, input in_ready, out_data, out_clk, underflow);
  modport slave  (input in_valid, in_data, output in_ready, out_data, out_clk, underflow);
endinterface

// File: rtl/prbs7_gen.sv
// PRBS7 generator producing OUT_W sequential bits per enabled cycle, bit 0 earliest.
module prbs7_gen
  import tmds_gearbox_pkg::*;
#(
  parameter int OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [OUT_W-1:0] bits
);
  logic [6:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    bits    = '0;
    for (int k = 0; k < OUT_W; k++) begin
      bits[k] = ^(state_d & PRBS7_TAPS);
      state_d = {state_d[5:0], bits[k]};
    end
    if (!en) state_d = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PRBS7_SEED;
    else        state_q <= state_d;
  end
endmodule

// File: rtl/tmds_gearbox.sv
// TMDS serialiser front end: SYM_W-bit symbols in, OUT_W bits per lane per cycle out.
// Optional PRBS7 test mode is built when TMDS_GEARBOX_PRBS_EN is defined.
module tmds_gearbox
  import tmds_gearbox_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int SYM_W    = TMDS_SYM_W,
  parameter int OUT_W    = 2
) (
  input  logic ser_clk,
  input  logic rst_n,
`ifdef TMDS_GEARBOX_PRBS_EN
  input  logic prbs_sel,
`endif
  tmds_gearbox_if.slave bus
);
  localparam int BUF_W  = SYM_W + OUT_W;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int POS_W  = $clog2(SYM_W + 1);

  logic [FILL_W-1:0]         fill_q, fill_d, fill_rem;
  logic [POS_W-1:0]          pos_q, pos_d, pos_adv;
  logic [POS_W:0]            pos_sum;
  logic                      armed_q, armed_d;
  logic                      underflow_q, underflow_d;
  logic [CHANNELS*OUT_W-1:0] out_data_q, out_data_d, lane_low;
  logic [OUT_W-1:0]          out_clk_q, out_clk_d, clk_vec, prbs_bits;
  logic                      take, accept, prbs_mode;

`ifdef TMDS_GEARBOX_PRBS_EN
  assign prbs_mode = prbs_sel;
  prbs7_gen #(.OUT_W(OUT_W)) u_prbs (
    .clk  (ser_clk),
    .rst_n(rst_n),
    .en   (prbs_sel),
    .bits (prbs_bits)
  );
`else
  assign prbs_mode = 1'b0;
  assign prbs_bits = '0;
`endif

  assign take     = fill_q >= FILL_W'(OUT_W);
  assign fill_rem = take ? fill_q - FILL_W'(OUT_W) : fill_q;
  // fill_rem + SYM_W <= BUF_W reduces to fill_rem <= OUT_W.
  assign bus.in_ready = (fill_rem <= FILL_W'(OUT_W)) && !prbs_mode;
  assign accept       = bus.in_valid && bus.in_ready;

  assign pos_sum = {1'b0, pos_q} + (POS_W+1)'(OUT_W);
  assign pos_adv = (pos_sum >= (POS_W+1)'(SYM_W)) ? POS_W'(pos_sum - (POS_W+1)'(SYM_W))
                                                  : POS_W'(pos_sum);

  always_comb begin
    clk_vec = '0;
    for (int k = 0; k < OUT_W; k++) clk_vec[k] = clk_bits(32'(pos_q), k, SYM_W);
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic [BUF_W-1:0] buf_q, buf_d, buf_sh;

      always_comb begin
        buf_sh = take ? (buf_q >> OUT_W) : buf_q;
        buf_d  = buf_sh;
        if (prbs_mode)   buf_d = '0;
        else if (accept) buf_d = buf_sh | (BUF_W'(bus.in_data[gi*SYM_W +: SYM_W]) << fill_rem);
      end

      always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) buf_q <= '0;
        else        buf_q <= buf_d;
      end

      assign lane_low[gi*OUT_W +: OUT_W] = buf_q[OUT_W-1:0];
    end
  endgenerate

  always_comb begin
    fill_d      = fill_q;
    pos_d       = pos_q;
    armed_d     = armed_q;
    underflow_d = underflow_q;
    out_data_d  = '0;
    out_clk_d   = '0;
    if (prbs_mode) begin
      fill_d     = '0;
      armed_d    = 1'b0;
      pos_d      = pos_adv;
      out_clk_d  = clk_vec;
      out_data_d = {CHANNELS{prbs_bits}};
    end else begin
      if (take) begin
        out_data_d = lane_low;
        out_clk_d  = clk_vec;
        pos_d      = pos_adv;
      end else if (armed_q) begin
        underflow_d = 1'b1;
      end
      fill_d  = accept ? fill_rem + FILL_W'(SYM_W) : fill_rem;
      armed_d = armed_q || accept;
    end
  end

  always_ff @(posedge ser_clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q      <= '0;
      pos_q       <= '0;
      armed_q     <= 1'b0;
      underflow_q <= 1'b0;
      out_data_q  <= '0;
      out_clk_q   <= '0;
    end else begin
      fill_q      <= fill_d;
      pos_q       <= pos_d;
      armed_q     <= armed_d;
      underflow_q <= underflow_d;
      out_data_q  <= out_data_d;
      out_clk_q   <= out_clk_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_clk   = out_clk_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_tmds_gearbox.sv
// Scoreboard bench for tmds_gearbox at OUT_W=2 and OUT_W=4 (SYM_W=10, 3 lanes).
module tb_tmds_gearbox;
  localparam int CH = 3;
  localparam int SW = 10;
  localparam int OP_SEND = 0, OP_IDLE = 1, OP_RST = 2, OP_CHK1 = 3, OP_CHKU = 4, OP_PRBS = 5;

  typedef struct {
    int          op;
    logic [29:0] data;
    int          n;
  } op_t;

  logic clk;
  int   checks = 0;
  int   fails  = 0;
  bit   done_g [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int OW = (gi == 0) ? 2 : 4;
      localparam int BW = SW + OW;

      logic rst_n_g = 1'b1;
`ifdef TMDS_GEARBOX_PRBS_EN
      logic prbs_sel_g = 1'b0;
`endif
      tmds_gearbox_if #(.CHANNELS(CH), .SYM_W(SW), .OUT_W(OW)) bus ();

      tmds_gearbox #(.CHANNELS(CH), .SYM_W(SW), .OUT_W(OW)) dut (
        .ser_clk (clk),
        .rst_n   (rst_n_g),
`ifdef TMDS_GEARBOX_PRBS_EN
        .prbs_sel(prbs_sel_g),
`endif
        .bus     (bus.slave)
      );

      // Scoreboard: bit columns (one bit per lane) awaiting transmission.
      logic [CH-1:0]    col_q [$];
      logic [CH-1:0]    col;
      logic [CH*OW-1:0] ed;
      logic [OW-1:0]    ec;
      logic [CH*SW-1:0] aw;
      logic [6:0]       ps;
      int               mpos;
      bit               marmed, munder, acc, psel, nb;

      initial begin
        forever begin
          @(negedge clk);
          if (!rst_n_g) begin
            col_q.delete(); mpos = 0; marmed = 0; munder = 0; ps = 7'h7F;
            continue;
          end
`ifdef TMDS_GEARBOX_PRBS_EN
          psel = prbs_sel_g;
`else
          psel = 1'b0;
`endif
          begin
            int f, tk;
            f  = col_q.size();
            tk = (f >= OW) ? OW : 0;
            check($sformatf("cfg%0d_in_ready", gi), 32'(bus.in_ready),
                  32'((!psel) && (f - tk + SW <= BW)));
          end
          acc = bus.in_valid && bus.in_ready;
          aw  = bus.in_data;
          @(posedge clk);
          #1;
          if (!rst_n_g) begin
            col_q.delete(); mpos = 0; marmed = 0; munder = 0; ps = 7'h7F;
            continue;
          end
          ed = '0;
          ec = '0;
          if (psel) begin
            col_q.delete();
            marmed = 0;
            for (int k = 0; k < OW; k++) begin
              nb = ps[6] ^ ps[5];
              ps = {ps[5:0], nb};
              for (int i = 0; i < CH; i++) ed[i*OW+k] = nb;
              ec[k] = ((mpos + k) % SW) < (SW / 2);
            end
            mpos = (mpos + OW) % SW;
          end else begin
            if (col_q.size() >= OW) begin
              for (int k = 0; k < OW; k++) begin
                col = col_q.pop_front();
                for (int i = 0; i < CH; i++) ed[i*OW+k] = col[i];
                ec[k] = ((mpos + k) % SW) < (SW / 2);
              end
              mpos = (mpos + OW) % SW;
            end else if (marmed) begin
              munder = 1;
            end
            if (acc) begin
              for (int j = 0; j < SW; j++) begin
                for (int i = 0; i < CH; i++) col[i] = aw[i*SW+j];
                col_q.push_back(col);
              end
              marmed = 1;
            end
          end
          check($sformatf("cfg%0d_out_data", gi), 32'(bus.out_data), 32'(ed));
          check($sformatf("cfg%0d_out_clk", gi), 32'(bus.out_clk), 32'(ec));
          check($sformatf("cfg%0d_underflow", gi), 32'(bus.underflow), 32'(munder));
        end
      end

      // Directed stimulus: a table of operations executed in order.
      op_t ops [$];
      logic [9:0] w [3];

      initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        w = '{10'h3FF, 10'h000, 10'h155};
        ops.push_back('{OP_RST, 30'd0, 2});
        if (gi == 0) begin
          ops.push_back('{OP_IDLE, 30'd0, 20});
          ops.push_back('{OP_CHKU, 30'd0, 0});
          for (int t = 0; t < 12; t++)
            ops.push_back('{OP_SEND, {w[(t+2)%3], w[(t+1)%3], w[t%3]}, 0});
          ops.push_back('{OP_IDLE, 30'd0, 3});
          ops.push_back('{OP_RST, 30'd0, 2});
          ops.push_back('{OP_SEND, {10'h003, 10'h002, 10'h001}, 0});
          ops.push_back('{OP_CHK1, 30'd0, 6'b111001});
          ops.push_back('{OP_SEND, {10'h155, 10'h3FF, 10'h000}, 0});
          ops.push_back('{OP_SEND, {10'h000, 10'h155, 10'h3FF}, 0});
          ops.push_back('{OP_IDLE, 30'd0, 7});
          for (int t = 0; t < 3; t++)
            ops.push_back('{OP_SEND, {w[t%3], w[(t+1)%3], w[(t+2)%3]}, 0});
          ops.push_back('{OP_IDLE, 30'd0, 2});
          ops.push_back('{OP_CHKU, 30'd0, 1});
`ifdef TMDS_GEARBOX_PRBS_EN
          ops.push_back('{OP_RST, 30'd0, 2});
          ops.push_back('{OP_PRBS, 30'd0, 64});
          ops.push_back('{OP_IDLE, 30'd0, 5});
          ops.push_back('{OP_CHKU, 30'd0, 0});
`endif
        end else begin
          for (int t = 0; t < 10; t++) begin
            logic [9:0] v;
            v = (t % 2 == 1) ? 10'h0F3 : 10'h2AB;
            ops.push_back('{OP_SEND, {v, ~v, v}, 0});
          end
          ops.push_back('{OP_IDLE, 30'd0, 4});
        end

        #2;
        foreach (ops[j]) begin
          op_t o;
          o = ops[j];
          case (o.op)
            OP_SEND: begin
              int n;
              bus.in_valid = 1'b1;
              bus.in_data  = o.data;
              n = 0;
              do begin
                @(negedge clk);
                n++;
              end while (!bus.in_ready && n < 20);
              if (!bus.in_ready) check($sformatf("cfg%0d_ready_wait", gi), 32'(bus.in_ready), 32'd1);
              @(posedge clk);
              #2;
              bus.in_valid = 1'b0;
            end
            OP_IDLE: begin
              bus.in_valid = 1'b0;
              repeat (o.n) @(posedge clk);
              #2;
            end
            OP_RST: begin
              bus.in_valid = 1'b0;
              rst_n_g = 1'b0;
              #1;
              check($sformatf("cfg%0d_rst_out_data", gi), 32'(bus.out_data), 32'd0);
              check($sformatf("cfg%0d_rst_out_clk", gi), 32'(bus.out_clk), 32'd0);
              check($sformatf("cfg%0d_rst_underflow", gi), 32'(bus.underflow), 32'd0);
              check($sformatf("cfg%0d_rst_in_ready", gi), 32'(bus.in_ready), 32'd1);
              repeat (o.n) @(posedge clk);
              #2;
              rst_n_g = 1'b1;
            end
            OP_CHK1: begin
              @(posedge clk);
              #1;
              check($sformatf("cfg%0d_first_data", gi), 32'(bus.out_data), 32'(o.n));
              check($sformatf("cfg%0d_first_clk", gi), 32'(bus.out_clk), 32'd3);
              #1;
            end
            OP_CHKU: begin
              check($sformatf("cfg%0d_sticky_underflow", gi), 32'(bus.underflow), 32'(o.n));
            end
            OP_PRBS: begin
`ifdef TMDS_GEARBOX_PRBS_EN
              prbs_sel_g   = 1'b1;
              bus.in_valid = 1'b1;
              repeat (o.n) @(posedge clk);
              #2;
              prbs_sel_g   = 1'b0;
              bus.in_valid = 1'b0;
`endif
            end
            default: ;
          endcase
        end
        done_g[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin
    for (int c = 0; c < 20000; c++) begin
      if (done_g[0] && done_g[1]) break;
      @(posedge clk);
    end
    check("all_done", 32'(done_g[0] && done_g[1]), 32'd1);
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
